// File: rtl/store_lane_steer.sv
// Store lane steering: aligns one store onto a word-wide memory write port with byte
// enables, splitting stores that straddle a word boundary into two beats.
module store_lane_steer #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  output logic              size_err
);

  // state | meaning
  // IDLE  | ready for a store request, no beat pending
  // BEAT0 | first (or only) memory beat presented
  // BEAT1 | second beat of a word-crossing store presented
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_n;
  logic [XLEN-1:0]   wdata_n;
  logic [3:0]        be_n;
  logic              err_n;
  logic [XLEN-1:0]   hi_wdata, hi_wdata_n;
  logic [3:0]        hi_be, hi_be_n;
  logic              split, split_n;

  logic [1:0]        off;
  logic [XLEN-1:0]   data_m;
  logic [7:0]        lane_m;
  logic [2*XLEN-1:0] shifted;
  logic [7:0]        be_full;

  // Lane math over a two-word window: the upper half holds whatever spills past lane 3.
  always_comb begin
    off    = req_addr[1:0];
    data_m = req_data;
    lane_m = 8'b0000_1111;
    case (req_size)
      2'b00: begin
        data_m = {{(XLEN-8){1'b0}}, req_data[7:0]};
        lane_m = 8'b0000_0001;
      end
      2'b01: begin
        data_m = {{(XLEN-16){1'b0}}, req_data[15:0]};
        lane_m = 8'b0000_0011;
      end
      default: begin
        data_m = req_data;
        lane_m = 8'b0000_1111;
      end
    endcase
    shifted = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
    be_full = lane_m << off;
  end

  always_comb begin
    state_n    = state;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    be_n       = mem_be;
    hi_wdata_n = hi_wdata;
    hi_be_n    = hi_be;
    split_n    = split;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_size == 2'b11) begin
            err_n = 1'b1;
          end else begin
            state_n    = BEAT0;
            addr_n     = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_n    = shifted[XLEN-1:0];
            be_n       = be_full[3:0];
            hi_wdata_n = shifted[2*XLEN-1:XLEN];
            hi_be_n    = be_full[7:4];
            split_n    = |be_full[7:4];
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (split) begin
            state_n = BEAT1;
            addr_n  = mem_addr + ADDR_W'(4);
            wdata_n = hi_wdata;
            be_n    = hi_be;
          end else begin
            state_n = IDLE;
            wdata_n = '0;
            be_n    = '0;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_n = IDLE;
          wdata_n = '0;
          be_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
        wdata_n = '0;
        be_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      size_err  <= 1'b0;
      hi_wdata  <= '0;
      hi_be     <= '0;
      split     <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      mem_valid <= (state_n != IDLE);
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_be    <= be_n;
      size_err  <= err_n;
      hi_wdata  <= hi_wdata_n;
      hi_be     <= hi_be_n;
      split     <= split_n;
    end
  end

endmodule

// File: tb/tb_store_lane_steer.sv
// Scoreboard bench for store_lane_steer: byte-level reference model feeds an expected-beat
// queue that an independent monitor drains on every memory handshake.
module tb_store_lane_steer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        size_err;

  store_lane_steer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .size_err  (size_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    rdy_mode = 0;   // 0 always ready, 1 random, 2 three-cycle stall per beat, 3 never
  int    stall_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: place each byte at its own address, grouping bytes by containing word.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int          n;
    beat_t       b0, b1;
    logic [31:0] w0, ba;
    bit          has1;
    int          lane;
    n    = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    b0   = '0;
    b1   = '0;
    has1 = 0;
    w0   = a & 32'hFFFF_FFFC;
    b0.addr = w0;
    for (int i = 0; i < n; i++) begin
      ba   = a + 32'(i);
      lane = int'(ba[1:0]);
      if ((ba & 32'hFFFF_FFFC) == w0) begin
        b0.wdata[8*lane +: 8] = d[8*i +: 8];
        b0.be[lane] = 1'b1;
      end else begin
        has1 = 1;
        b1.addr = ba & 32'hFFFF_FFFC;
        b1.wdata[8*lane +: 8] = d[8*i +: 8];
        b1.be[lane] = 1'b1;
      end
    end
    exp_q.push_back(b0);
    if (has1) exp_q.push_back(b1);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = 1'($urandom_range(0, 1));
      2: begin
        if (mem_valid) begin
          if (stall_cnt < 3) begin
            mem_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_ready = 1'b1;
            stall_cnt = 0;
          end
        end else begin
          mem_ready = 1'b0;
          stall_cnt = 0;
        end
      end
      default: mem_ready = 1'b0;
    endcase
  end

  beat_t mon_e;
  beat_t prev_b;
  bit    prev_stall = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(mem_valid), 32'd1);
        chk("hold_addr", mem_addr, prev_b.addr);
        chk("hold_wdata", mem_wdata, prev_b.wdata);
        chk("hold_be", 32'(mem_be), 32'(prev_b.be));
      end
      if (mem_valid) chk("ready_busy", 32'(req_ready), 32'd0);
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got addr 0x%08h be %b, expected no beat", mem_addr, mem_be);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_addr", mem_addr, mon_e.addr);
          chk("beat_wdata", mem_wdata, mon_e.wdata);
          chk("beat_be", 32'(mem_be), 32'(mon_e.be));
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_b = '{addr: mem_addr, wdata: mem_wdata, be: mem_be};
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    if (s != 2'b11) model(a, d, s);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    @(negedge clk);
    if (s == 2'b11) begin
      chk("size_err_pulse", 32'(size_err), 32'd1);
      chk("size_err_no_beat", 32'(mem_valid), 32'd0);
      @(negedge clk);
      chk("size_err_clear", 32'(size_err), 32'd0);
    end else begin
      chk("beat0_latency", 32'(mem_valid), 32'd1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0 || !req_ready) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_size_err", 32'(size_err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    rdy_mode = 0;
    send(32'h0000_0100, 32'hAABB_CCDD, 2'b10); drain();
    send(32'h0000_0103, 32'hFFFF_FFEE, 2'b00); drain();
    send(32'h0000_0103, 32'h0000_1234, 2'b01); drain();
    rdy_mode = 2;
    send(32'h0000_0101, 32'h1122_3344, 2'b10); drain();
    rdy_mode = 0;
    send(32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10); drain();
    chk("idle_be_zero", 32'(mem_be), 32'd0);
    chk("idle_valid_zero", 32'(mem_valid), 32'd0);

    // Reset while the second beat of a split half-word store is pending.
    rdy_mode = 2;
    send(32'h0000_0103, 32'h0000_1234, 2'b01);
    t = 0;
    while (!(mem_valid && mem_addr == 32'h0000_0104) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("beat1_seen", 32'(mem_valid && mem_addr == 32'h0000_0104), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_valid", 32'(mem_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_be", 32'(mem_be), 32'd0);
    rdy_mode = 0;
    send(32'h0000_0200, 32'h1234_5678, 2'b11); drain();

    for (int k = 0; k < 150; k++) begin
      rdy_mode = int'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      send(a, $urandom, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    rdy_mode = 1;
    drain();

    summary();
    $finish;
  end

endmodule
